// File: rtl/dds_wave_osc.sv
// ---------------------------------------------------------------------------
// dds_wave_osc
//
// Direct-digital-synthesis oscillator, one instance per voice. A phase
// accumulator advances by the tuning word once per frame strobe; the captured
// phase is mapped to one of four waveforms (sine, square, saw, triangle) and
// presented as an unsigned offset-binary sample two clocks later.
//
// Ports
//   BIT_CLK    in   1        sole clock, rising edge
//   RESET      in   1        asynchronous active-high reset
//   frame_sig  in   1        sample strobe, one cycle per sample
//   en         in   1        load strobe for TUNE_IN / MODE_IN
//   sync       in   1        hard sync: phase reset to zero
//   TUNE_IN    in   PHASE_W  new tuning word
//   MODE_IN    in   2        new mode: 0 sine, 1 square, 2 saw, 3 triangle
//   TUNE       out  PHASE_W  active tuning word
//   MODE       out  2        active mode
//   WAVE_OUT   out  OUT_W    current sample, held between samples
//   VALID      out  1        one-cycle pulse when WAVE_OUT updates
// ---------------------------------------------------------------------------
module dds_wave_osc #(
    parameter int                 OUT_W    = 18,
    parameter int                 PHASE_W  = 24,
    parameter int                 LUT_AW   = 6,
    parameter logic [PHASE_W-1:0] TUNE_RST = 24'd65536
) (
    input  logic               BIT_CLK,
    input  logic               RESET,
    input  logic               frame_sig,
    input  logic               en,
    input  logic               sync,
    input  logic [PHASE_W-1:0] TUNE_IN,
    input  logic [1:0]         MODE_IN,
    output logic [PHASE_W-1:0] TUNE,
    output logic [1:0]         MODE,
    output logic [OUT_W-1:0]   WAVE_OUT,
    output logic               VALID
);

    localparam int LUT_N = 2 ** LUT_AW;

    // Only the top phase bits ever reach the waveform mappers, so the
    // pipeline carries just those. Triangle needs OUT_W+1 bits, sine needs
    // two quadrant bits plus the table index.
    localparam int CAP_W = ((OUT_W + 1) > (LUT_AW + 2)) ? (OUT_W + 1) : (LUT_AW + 2);

    localparam logic [OUT_W-1:0]  MID      = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  MAX      = {OUT_W{1'b1}};
    localparam logic [LUT_AW:0]   LUT_SPAN = {1'b1, {LUT_AW{1'b0}}};

    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_SAW    = 2'd2;
    localparam logic [1:0] MODE_TRI    = 2'd3;

    // -----------------------------------------------------------------------
    // Quarter-wave table entry k: round(A * sin(pi/2 * k / 2^LUT_AW)).
    // Evaluated at elaboration with a Taylor series so no math library or
    // memory file is needed; 12 terms are far below one LSB of error over
    // the [0, pi/2] argument range.
    // -----------------------------------------------------------------------
    function automatic logic [OUT_W-1:0] quarter_sin(input int k);
        real x;
        real term;
        real acc;
        real amp;
        x    = 1.5707963267948966 * real'(k) / real'(LUT_N);
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = real'((2 ** (OUT_W - 1)) - 1);
        return OUT_W'($rtoi(amp * acc + 0.5));
    endfunction

    logic [OUT_W-1:0] qtab [0:LUT_N];

    for (genvar k = 0; k <= LUT_N; k++) begin : g_qtab
        localparam logic [OUT_W-1:0] QV = quarter_sin(k);
        assign qtab[k] = QV;
    end

    // -----------------------------------------------------------------------
    // Internal state
    // -----------------------------------------------------------------------
    logic [PHASE_W-1:0] phase_r;
    logic [PHASE_W-1:0] phase_start_s;

    logic [CAP_W-1:0]   p0_r;
    logic [1:0]         m0_r;
    logic               v0_r;

    logic [OUT_W-1:0]   s1_r;
    logic               v1_r;

    logic [1:0]         quad_s;
    logic [LUT_AW-1:0]  idx_s;
    logic [LUT_AW:0]    idx_dir_s;
    logic [LUT_AW:0]    idx_mir_s;
    logic [OUT_W-1:0]   q_dir_s;
    logic [OUT_W-1:0]   q_mir_s;
    logic [OUT_W-1:0]   sine_s;
    logic [OUT_W-1:0]   tri_s;
    logic [OUT_W-1:0]   wave_s;

    // Active tuning word and mode; loaded on en, independent of the strobe.
    always_ff @(posedge BIT_CLK or posedge RESET) begin
        if (RESET) begin
            TUNE <= TUNE_RST;
            MODE <= MODE_SINE;
        end else if (en) begin
            TUNE <= TUNE_IN;
            MODE <= MODE_IN;
        end else begin
            TUNE <= TUNE;
            MODE <= MODE;
        end
    end

    // Phase the current strobe starts from; a same-cycle sync forces zero.
    always_comb begin
        phase_start_s = phase_r;
        if (sync) begin
            phase_start_s = '0;
        end else begin
            phase_start_s = phase_r;
        end
    end

    // Stage 0: capture phase/mode on a strobe and advance the accumulator.
    // TUNE and MODE here are the pre-load values, so a same-cycle en only
    // affects later strobes.
    always_ff @(posedge BIT_CLK or posedge RESET) begin
        if (RESET) begin
            phase_r <= '0;
            p0_r    <= '0;
            m0_r    <= MODE_SINE;
            v0_r    <= 1'b0;
        end else begin
            v0_r <= frame_sig;
            if (frame_sig) begin
                p0_r    <= phase_start_s[PHASE_W-1 -: CAP_W];
                m0_r    <= MODE;
                phase_r <= phase_start_s + TUNE;
            end else if (sync) begin
                p0_r    <= p0_r;
                m0_r    <= m0_r;
                phase_r <= '0;
            end else begin
                p0_r    <= p0_r;
                m0_r    <= m0_r;
                phase_r <= phase_r;
            end
        end
    end

    // Sine by quadrant symmetry: quadrants 1 and 3 read the table mirrored
    // (index 2^LUT_AW - i), quadrants 2 and 3 subtract from mid-scale.
    always_comb begin
        quad_s    = p0_r[CAP_W-1 -: 2];
        idx_s     = p0_r[CAP_W-3 -: LUT_AW];
        idx_dir_s = {1'b0, idx_s};
        idx_mir_s = LUT_SPAN - idx_dir_s;
        q_dir_s   = qtab[idx_dir_s];
        q_mir_s   = qtab[idx_mir_s];
        case (quad_s)
            2'd0:    sine_s = MID + q_dir_s;
            2'd1:    sine_s = MID + q_mir_s;
            2'd2:    sine_s = MID - q_dir_s;
            2'd3:    sine_s = MID - q_mir_s;
            default: sine_s = MID;
        endcase
    end

    // Triangle folds the second half-cycle by inverting the ramp below MSB.
    always_comb begin
        tri_s = p0_r[CAP_W-2 -: OUT_W];
        if (p0_r[CAP_W-1]) begin
            tri_s = ~p0_r[CAP_W-2 -: OUT_W];
        end else begin
            tri_s = p0_r[CAP_W-2 -: OUT_W];
        end
    end

    // Waveform select for the captured mode.
    always_comb begin
        case (m0_r)
            MODE_SINE:   wave_s = sine_s;
            MODE_SQUARE: wave_s = p0_r[CAP_W-1] ? {OUT_W{1'b0}} : MAX;
            MODE_SAW:    wave_s = p0_r[CAP_W-1 -: OUT_W];
            MODE_TRI:    wave_s = tri_s;
            default:     wave_s = MID;
        endcase
    end

    // Stage 1: register the mapped sample.
    always_ff @(posedge BIT_CLK or posedge RESET) begin
        if (RESET) begin
            s1_r <= MID;
            v1_r <= 1'b0;
        end else begin
            v1_r <= v0_r;
            if (v0_r) begin
                s1_r <= wave_s;
            end else begin
                s1_r <= s1_r;
            end
        end
    end

    // Stage 2: present the sample; WAVE_OUT holds until the next one.
    always_ff @(posedge BIT_CLK or posedge RESET) begin
        if (RESET) begin
            WAVE_OUT <= MID;
            VALID    <= 1'b0;
        end else begin
            VALID <= v1_r;
            if (v1_r) begin
                WAVE_OUT <= s1_r;
            end else begin
                WAVE_OUT <= WAVE_OUT;
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_osc.sv
// ---------------------------------------------------------------------------
// tb_dds_wave_osc
//
// Self-checking bench for dds_wave_osc at default parameters. A behavioural
// model of the phase accumulator computes each expected sample when its
// strobe is driven and queues it with the cycle it must appear on; observed
// VALID samples are queued by the stepping task and each scenario task
// compares the two queues.
// ---------------------------------------------------------------------------
module tb_dds_wave_osc;

    localparam real PI = 3.14159265358979323846;

    logic        BIT_CLK = 1'b0;
    logic        RESET;
    logic        frame_sig;
    logic        en;
    logic        sync;
    logic [23:0] TUNE_IN;
    logic [1:0]  MODE_IN;
    logic [23:0] TUNE;
    logic [1:0]  MODE;
    logic [17:0] WAVE_OUT;
    logic        VALID;

    dds_wave_osc dut (
        .BIT_CLK   (BIT_CLK),
        .RESET     (RESET),
        .frame_sig (frame_sig),
        .en        (en),
        .sync      (sync),
        .TUNE_IN   (TUNE_IN),
        .MODE_IN   (MODE_IN),
        .TUNE      (TUNE),
        .MODE      (MODE),
        .WAVE_OUT  (WAVE_OUT),
        .VALID     (VALID)
    );

    always #5 BIT_CLK = ~BIT_CLK;

    typedef struct {
        logic [17:0] val;
        int          cyc;
    } smp_t;

    smp_t exp_q[$];
    smp_t obs_q[$];

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    logic [23:0] m_phase;
    logic [23:0] m_tune;
    logic [1:0]  m_mode;

    // Reference waveform from the mathematical definitions.
    function automatic logic [17:0] exp_wave(input logic [23:0] p, input logic [1:0] m);
        int          k;
        real         s;
        int          r;
        logic [17:0] t;
        case (m)
            2'd0: begin
                k = int'(p >> 16);
                s = 131071.0 * $sin(2.0 * PI * real'(k) / 256.0);
                r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
                return 18'(131071 + r);
            end
            2'd1: return p[23] ? 18'd0 : 18'd262143;
            2'd2: return p[23:6];
            default: begin
                t = p[22:5];
                return p[23] ? ~t : t;
            end
        endcase
    endfunction

    // One clock: drive inputs, advance the model, record any VALID sample.
    task automatic step(input logic f, input logic e, input logic s,
                        input logic [23:0] ti, input logic [1:0] mi);
        logic [23:0] p;
        frame_sig = f;
        en        = e;
        sync      = s;
        TUNE_IN   = ti;
        MODE_IN   = mi;
        if (!RESET) begin
            if (f) begin
                p = s ? 24'd0 : m_phase;
                exp_q.push_back('{exp_wave(p, m_mode), cyc + 3});
                m_phase = p + m_tune;
            end else if (s) begin
                m_phase = 24'd0;
            end
            if (e) begin
                m_tune = ti;
                m_mode = mi;
            end
        end
        @(posedge BIT_CLK);
        #1;
        cyc++;
        if (VALID === 1'b1) obs_q.push_back('{WAVE_OUT, cyc});
        frame_sig = 1'b0;
        en        = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'd0, 2'd0);
    endtask

    task automatic test_reset();
        smp_t o, x;
        RESET = 1'b1; frame_sig = 1'b0; en = 1'b0; sync = 1'b0;
        TUNE_IN = 24'd0; MODE_IN = 2'd0;
        m_phase = 24'd0; m_tune = 24'd65536; m_mode = 2'd0;
        #2;
        ntests += 4;
        if (WAVE_OUT !== 18'd131071) begin nfail++; $display("FAIL reset_wave: got %0d, expected 131071", WAVE_OUT); end
        if (VALID !== 1'b0)          begin nfail++; $display("FAIL reset_valid: got %0b, expected 0", VALID); end
        if (TUNE !== 24'd65536)      begin nfail++; $display("FAIL reset_tune: got %0d, expected 65536", TUNE); end
        if (MODE !== 2'd0)           begin nfail++; $display("FAIL reset_mode: got %0d, expected 0", MODE); end
        @(posedge BIT_CLK); #1;
        RESET = 1'b0;
        // Change tune/mode so a later reset is visible, then fill the pipe.
        step(1'b0, 1'b1, 1'b0, 24'd1048576, 2'd2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        RESET = 1'b1;
        #1;
        ntests += 4;
        if (WAVE_OUT !== 18'd131071) begin nfail++; $display("FAIL midreset_wave: got %0d, expected 131071", WAVE_OUT); end
        if (VALID !== 1'b0)          begin nfail++; $display("FAIL midreset_valid: got %0b, expected 0", VALID); end
        if (TUNE !== 24'd65536)      begin nfail++; $display("FAIL midreset_tune: got %0d, expected 65536", TUNE); end
        if (MODE !== 2'd0)           begin nfail++; $display("FAIL midreset_mode: got %0d, expected 0", MODE); end
        // In-flight samples are discarded; the model restarts from reset.
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        m_phase = 24'd0; m_tune = 24'd65536; m_mode = 2'd0;
        idle(2);
        RESET = 1'b0;
        idle(6);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front();
            ntests++;
            if (o.val !== x.val || o.cyc !== x.cyc) begin
                nfail++;
                $display("FAIL reset_sample: got %0d at cycle %0d, expected %0d at cycle %0d", o.val, o.cyc, x.val, x.cyc);
            end
        end
        ntests++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            nfail++;
            $display("FAIL reset_count: %0d unexpected VALID, %0d missing", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_sine_back_to_back();
        smp_t o, x;
        logic [17:0] k_sine [4] = '{18'd131071, 18'd262142, 18'd131071, 18'd0};
        int j = 0;
        for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        idle(3);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front();
            ntests++;
            if (o.val !== x.val || o.cyc !== x.cyc) begin
                nfail++;
                $display("FAIL sine_sample%0d: got %0d at cycle %0d, expected %0d at cycle %0d", j, o.val, o.cyc, x.val, x.cyc);
            end
            if (j % 64 == 0) begin
                ntests++;
                if (o.val !== k_sine[(j / 64) % 4]) begin
                    nfail++;
                    $display("FAIL sine_point%0d: got %0d, expected %0d", j, o.val, k_sine[(j / 64) % 4]);
                end
            end
            j++;
        end
        ntests++;
        if (obs_q.size() != 0 || exp_q.size() != 0 || j != 260) begin
            nfail++;
            $display("FAIL sine_count: got %0d samples, expected 260 (%0d extra, %0d missing)", j, obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_modes();
        smp_t o, x;
        logic [1:0]  modes [3] = '{2'd1, 2'd2, 2'd3};
        logic [23:0] tunes [3] = '{24'd4194304, 24'd8388608, 24'd4194304};
        int          gaps  [3] = '{4, 1, 1};
        logic [17:0] pat   [12] = '{18'd262143, 18'd262143, 18'd0, 18'd0,
                                    18'd0, 18'd131072, 18'd0, 18'd131072,
                                    18'd0, 18'd131072, 18'd262143, 18'd131071};
        for (int mi = 0; mi < 3; mi++) begin
            int j = 0;
            step(1'b0, 1'b1, 1'b0, tunes[mi], modes[mi]);
            ntests++;
            if (TUNE !== tunes[mi] || MODE !== modes[mi]) begin
                nfail++;
                $display("FAIL mode%0d_load: got TUNE=%0d MODE=%0d, expected %0d/%0d", modes[mi], TUNE, MODE, tunes[mi], modes[mi]);
            end
            step(1'b0, 1'b0, 1'b1, 24'd0, 2'd0);
            idle(2);
            ntests++;
            if (obs_q.size() != 0) begin
                nfail++;
                $display("FAIL mode%0d_nopulse: got %0d VALID pulses from en/sync, expected 0", modes[mi], obs_q.size());
                obs_q.delete();
            end
            for (int s = 0; s < 8; s++) begin
                step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
                idle(gaps[mi] - 1);
            end
            idle(3);
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front(); x = exp_q.pop_front();
                ntests += 2;
                if (o.val !== x.val || o.cyc !== x.cyc) begin
                    nfail++;
                    $display("FAIL mode%0d_sample%0d: got %0d at cycle %0d, expected %0d at cycle %0d", modes[mi], j, o.val, o.cyc, x.val, x.cyc);
                end
                if (o.val !== pat[mi * 4 + (j % 4)]) begin
                    nfail++;
                    $display("FAIL mode%0d_pattern%0d: got %0d, expected %0d", modes[mi], j, o.val, pat[mi * 4 + (j % 4)]);
                end
                j++;
            end
            ntests++;
            if (obs_q.size() != 0 || exp_q.size() != 0 || j != 8) begin
                nfail++;
                $display("FAIL mode%0d_count: got %0d samples, expected 8", modes[mi], j);
                obs_q.delete(); exp_q.delete();
            end
        end
    endtask

    task automatic test_en_same_cycle();
        smp_t o, x;
        logic [17:0] want [5] = '{18'd131071, 18'd262143, 18'd262143, 18'd5120, 18'd6144};
        int j = 0;
        step(1'b0, 1'b1, 1'b0, 24'd65536, 2'd0);
        step(1'b0, 1'b0, 1'b1, 24'd0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 24'd131072, 2'd1);
        ntests++;
        if (TUNE !== 24'd131072 || MODE !== 2'd1) begin
            nfail++;
            $display("FAIL en_load: got TUNE=%0d MODE=%0d, expected 131072/1", TUNE, MODE);
        end
        step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 24'd65536, 2'd2);
        step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        idle(3);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front();
            ntests += 2;
            if (o.val !== x.val || o.cyc !== x.cyc) begin
                nfail++;
                $display("FAIL en_sample%0d: got %0d at cycle %0d, expected %0d at cycle %0d", j, o.val, o.cyc, x.val, x.cyc);
            end
            if (o.val !== want[j]) begin
                nfail++;
                $display("FAIL en_value%0d: got %0d, expected %0d", j, o.val, want[j]);
            end
            j++;
        end
        ntests++;
        if (obs_q.size() != 0 || exp_q.size() != 0 || j != 5) begin
            nfail++;
            $display("FAIL en_count: got %0d samples, expected 5", j);
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_sync();
        smp_t o, x;
        int j = 0;
        step(1'b0, 1'b1, 1'b0, 24'd65536, 2'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        step(1'b1, 1'b0, 1'b1, 24'd0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 24'd0, 2'd0);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        idle(3);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front();
            ntests++;
            if (o.val !== x.val || o.cyc !== x.cyc) begin
                nfail++;
                $display("FAIL sync_sample%0d: got %0d at cycle %0d, expected %0d at cycle %0d", j, o.val, o.cyc, x.val, x.cyc);
            end
            if (j == 5 || j == 8) begin
                ntests++;
                if (o.val !== 18'd131071) begin
                    nfail++;
                    $display("FAIL sync_zero%0d: got %0d, expected 131071", j, o.val);
                end
            end
            j++;
        end
        ntests++;
        if (obs_q.size() != 0 || exp_q.size() != 0 || j != 9) begin
            nfail++;
            $display("FAIL sync_count: got %0d samples, expected 9", j);
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_tune_zero();
        smp_t o, x;
        int j = 0;
        step(1'b0, 1'b1, 1'b0, 24'd0, 2'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 24'd0, 2'd0);
        idle(3);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front();
            ntests++;
            if (o.val !== x.val || o.cyc !== x.cyc) begin
                nfail++;
                $display("FAIL tune0_sample%0d: got %0d at cycle %0d, expected %0d at cycle %0d", j, o.val, o.cyc, x.val, x.cyc);
            end
            j++;
        end
        ntests++;
        if (obs_q.size() != 0 || exp_q.size() != 0 || j != 4) begin
            nfail++;
            $display("FAIL tune0_count: got %0d samples, expected 4", j);
            obs_q.delete(); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_sine_back_to_back();
        test_modes();
        test_en_same_cycle();
        test_sync();
        test_tune_zero();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
